// File: rtl/rom_prefetch_if.sv
// rtl/rom_prefetch_if.sv - ROM address/data, instruction stream and jump signals for rom_prefetch
//
// Purpose: bundles every non-clock, non-reset signal of the instruction
// prefetcher so the fetch unit and its environment share one connection.
//
// Parameters:
//   ADDR_WIDTH   ROM address width
//
// Signals:
//   ROM_ADDR     fetch unit -> ROM   read address
//   ROM_DATA     ROM -> fetch unit   read data, one cycle after ROM_ADDR is sampled
//   INSTR_DATA   fetch unit -> CPU   FIFO head byte
//   INSTR_ADDR   fetch unit -> CPU   ROM address of the FIFO head byte
//   INSTR_VALID  fetch unit -> CPU   FIFO non-empty
//   INSTR_READY  CPU -> fetch unit   consumer pop (VALID & READY)
//   JUMP_EN      CPU -> fetch unit   single-cycle redirect strobe
//   JUMP_ADDR    CPU -> fetch unit   redirect target
//
// Modports:
//   master  the prefetcher (rom_prefetch)
//   slave   the ROM + CPU side driving it

interface rom_prefetch_if #(
   parameter int ADDR_WIDTH = 8
);

   logic [ADDR_WIDTH-1:0] ROM_ADDR;
   logic [7:0]            ROM_DATA;
   logic [7:0]            INSTR_DATA;
   logic [ADDR_WIDTH-1:0] INSTR_ADDR;
   logic                  INSTR_VALID;
   logic                  INSTR_READY;
   logic                  JUMP_EN;
   logic [ADDR_WIDTH-1:0] JUMP_ADDR;

   modport master (
      output ROM_ADDR,
      input  ROM_DATA,
      output INSTR_DATA,
      output INSTR_ADDR,
      output INSTR_VALID,
      input  INSTR_READY,
      input  JUMP_EN,
      input  JUMP_ADDR
   );

   modport slave (
      input  ROM_ADDR,
      output ROM_DATA,
      input  INSTR_DATA,
      input  INSTR_ADDR,
      input  INSTR_VALID,
      output INSTR_READY,
      output JUMP_EN,
      output JUMP_ADDR
   );

endinterface

// File: rtl/rom_prefetch.sv
// rtl/rom_prefetch.sv - instruction prefetcher for a synchronous program ROM
//
// Purpose: walks a fetch PC over the ROM, absorbs the ROM's one-cycle
// registered read latency with a single in-flight slot, and buffers fetched
// bytes (with their addresses) in a show-ahead FIFO offered to the CPU with a
// valid/ready handshake. A jump flushes the FIFO, drops the in-flight byte and
// restarts fetching at the jump target.
//
// Parameters:
//   ADDR_WIDTH   ROM address width; fetch PC wraps modulo 2^ADDR_WIDTH
//   DEPTH        FIFO entries, power of two in 2..16
//   RESET_ADDR   first address fetched after reset
//
// Ports:
//   CLK          sole clock, rising edge
//   RESETn       asynchronous active-low reset
//   bus          rom_prefetch_if.master (ROM bus, instruction stream, jump)
//
// Configuration macro:
//   ROM_PREFETCH_WRAP_EN  defined: fetch PC wraps from the top address to 0
//                         and fetching continues.
//                         undefined: after the top address is issued a halt
//                         flag stops further issue until a jump or reset.

module rom_prefetch #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic           CLK,
   input  logic           RESETn,
   rom_prefetch_if.master bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   logic [ADDR_WIDTH-1:0] pc;
   logic                  inflight_v;
   logic [ADDR_WIDTH-1:0] inflight_tag;

   logic [7:0]            fifo_data [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;

   logic                  halt;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [CW:0]           occ_after_pop;

   // A pop is only real when the head is valid; READY alone does nothing.
   assign pop  = (count != '0) && bus.INSTR_READY;

   // The in-flight byte lands in the FIFO on the edge after its address was
   // presented; a jump on that edge drops it instead.
   assign push = inflight_v && !bus.JUMP_EN;

   // Reserve a FIFO slot for the byte already in flight so the buffer can
   // never overflow. count >= pop always holds, so this cannot underflow.
   always_comb begin
      occ_after_pop = {1'b0, count}
                    + {{CW{1'b0}}, inflight_v}
                    - {{CW{1'b0}}, pop};
   end

   assign issue = (occ_after_pop < DEPTH_W) && !bus.JUMP_EN && !halt;

`ifdef ROM_PREFETCH_WRAP_EN
   assign halt = 1'b0;
`else
   // Set once the top address has been issued; PC itself still wraps to 0
   // but nothing is fetched from there until a jump redirects the stream.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         halt <= 1'b0;
      end else if (bus.JUMP_EN) begin
         halt <= 1'b0;
      end else if (issue && (pc == '1)) begin
         halt <= 1'b1;
      end
   end
`endif

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         pc           <= RESET_ADDR;
         inflight_v   <= 1'b0;
         inflight_tag <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_addr[i] <= '0;
         end
      end else if (bus.JUMP_EN) begin
         // Jump wins over everything: flush, drop the returning byte, and
         // discard any pop requested this same cycle.
         pc         <= bus.JUMP_ADDR;
         inflight_v <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
      end else begin
         if (issue) begin
            pc           <= pc + 1'b1;
            inflight_v   <= 1'b1;
            inflight_tag <= pc;
         end else begin
            inflight_v   <= 1'b0;
         end

         if (push) begin
            fifo_data[wr_ptr] <= bus.ROM_DATA;
            fifo_addr[wr_ptr] <= inflight_tag;
            wr_ptr            <= wr_ptr + 1'b1;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ROM_ADDR tracks the PC every cycle; the ROM sampling an address that is
   // not issued is harmless because its data is only taken via the slot.
   assign bus.ROM_ADDR    = pc;
   assign bus.INSTR_VALID = (count != '0);
   assign bus.INSTR_DATA  = fifo_data[rd_ptr];
   assign bus.INSTR_ADDR  = fifo_addr[rd_ptr];

endmodule

// File: tb/tb_rom_prefetch.sv
// tb/tb_rom_prefetch.sv - self-checking testbench for rom_prefetch

module tb_rom_prefetch;

   logic CLK;
   logic RESETn;
   int   n_checks;
   int   n_fail;

   logic [7:0] rom [256];

   rom_prefetch_if #(.ADDR_WIDTH(8)) bus ();

   rom_prefetch #(
      .ADDR_WIDTH (8),
      .DEPTH      (4),
      .RESET_ADDR (8'h00)
   ) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous ROM: one-cycle registered read.
   always @(posedge CLK) bus.ROM_DATA <= rom[bus.ROM_ADDR];

   task automatic apply_reset();
      @(negedge CLK);
      RESETn          = 1'b0;
      bus.INSTR_READY = 1'b0;
      bus.JUMP_EN     = 1'b0;
      bus.JUMP_ADDR   = 8'h00;
      @(negedge CLK);
      @(negedge CLK);
      RESETn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      RESETn          = 1'b0;
      bus.INSTR_READY = 1'b0;
      bus.JUMP_EN     = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.INSTR_VALID); end
      n_checks++;
      if (bus.ROM_ADDR !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr got %h want 00", bus.ROM_ADDR); end
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h00) begin n_fail++; $display("FAIL reset_instr_addr got %h want 00", bus.INSTR_ADDR); end
      n_checks++;
      if (bus.INSTR_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_instr_data got %h want 00", bus.INSTR_DATA); end
      RESETn = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL edge1_valid got %b want 0", bus.INSTR_VALID); end
      n_checks++;
      if (bus.ROM_ADDR !== 8'h01) begin n_fail++; $display("FAIL edge1_rom_addr got %h want 01", bus.ROM_ADDR); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL edge2_valid got %b want 1", bus.INSTR_VALID); end
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h00) begin n_fail++; $display("FAIL edge2_addr got %h want 00", bus.INSTR_ADDR); end
      n_checks++;
      if (bus.INSTR_DATA !== 8'hA5) begin n_fail++; $display("FAIL edge2_data got %h want a5", bus.INSTR_DATA); end
   endtask

   task automatic test_stream();
      logic [7:0] ea;
      apply_reset();
      bus.INSTR_READY = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      for (int i = 0; i < 12; i++) begin
         ea = 8'(i);
         n_checks++;
         if (bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", i, bus.INSTR_VALID); end
         n_checks++;
         if (bus.INSTR_ADDR !== ea) begin n_fail++; $display("FAIL stream_addr[%0d] got %h want %h", i, bus.INSTR_ADDR, ea); end
         n_checks++;
         if (bus.INSTR_DATA !== (ea ^ 8'hA5)) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, bus.INSTR_DATA, ea ^ 8'hA5); end
         @(negedge CLK);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ea;
      apply_reset();
      repeat (10) @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid got %b want 1", bus.INSTR_VALID); end
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h00) begin n_fail++; $display("FAIL bp_full_head got %h want 00", bus.INSTR_ADDR); end
      n_checks++;
      if (bus.ROM_ADDR !== 8'h04) begin n_fail++; $display("FAIL bp_full_pc got %h want 04", bus.ROM_ADDR); end
      bus.INSTR_READY = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ea = 8'(i);
         n_checks++;
         if (bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.INSTR_VALID); end
         n_checks++;
         if (bus.INSTR_ADDR !== ea) begin n_fail++; $display("FAIL bp_addr[%0d] got %h want %h", i, bus.INSTR_ADDR, ea); end
         n_checks++;
         if (bus.INSTR_DATA !== (ea ^ 8'hA5)) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, bus.INSTR_DATA, ea ^ 8'hA5); end
         @(negedge CLK);
      end
   endtask

   task automatic test_jump_flush();
      apply_reset();
      repeat (4) @(negedge CLK);
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h00 || bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL jf_pre head got %h/%b want 00/1", bus.INSTR_ADDR, bus.INSTR_VALID); end
      bus.JUMP_EN   = 1'b1;
      bus.JUMP_ADDR = 8'h40;
      @(negedge CLK);
      bus.JUMP_EN = 1'b0;
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL jf_j1_valid got %b want 0", bus.INSTR_VALID); end
      n_checks++;
      if (bus.ROM_ADDR !== 8'h40) begin n_fail++; $display("FAIL jf_j1_rom_addr got %h want 40", bus.ROM_ADDR); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL jf_j2_valid got %b want 0", bus.INSTR_VALID); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'h40) begin n_fail++; $display("FAIL jf_head got %b/%h want 1/40", bus.INSTR_VALID, bus.INSTR_ADDR); end
      n_checks++;
      if (bus.INSTR_DATA !== (8'h40 ^ 8'hA5)) begin n_fail++; $display("FAIL jf_data got %h want %h", bus.INSTR_DATA, 8'h40 ^ 8'hA5); end
      bus.INSTR_READY = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h41) begin n_fail++; $display("FAIL jf_next1 got %h want 41", bus.INSTR_ADDR); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h42) begin n_fail++; $display("FAIL jf_next2 got %h want 42", bus.INSTR_ADDR); end
   endtask

   task automatic test_jump_pop();
      apply_reset();
      bus.INSTR_READY = 1'b1;
      repeat (5) @(negedge CLK);
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h03 || bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL jp_pre head got %h/%b want 03/1", bus.INSTR_ADDR, bus.INSTR_VALID); end
      bus.JUMP_EN   = 1'b1;
      bus.JUMP_ADDR = 8'h80;
      @(negedge CLK);
      bus.JUMP_EN = 1'b0;
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL jp_j1_valid got %b want 0", bus.INSTR_VALID); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL jp_j2_valid got %b want 0", bus.INSTR_VALID); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'h80) begin n_fail++; $display("FAIL jp_head got %b/%h want 1/80", bus.INSTR_VALID, bus.INSTR_ADDR); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h81) begin n_fail++; $display("FAIL jp_next got %h want 81", bus.INSTR_ADDR); end
   endtask

   task automatic test_wrap();
      apply_reset();
      bus.INSTR_READY = 1'b1;
      repeat (3) @(negedge CLK);
      bus.JUMP_EN   = 1'b1;
      bus.JUMP_ADDR = 8'hFE;
      @(negedge CLK);
      bus.JUMP_EN = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'hFE) begin n_fail++; $display("FAIL wrap_fe got %b/%h want 1/fe", bus.INSTR_VALID, bus.INSTR_ADDR); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'hFF) begin n_fail++; $display("FAIL wrap_ff got %b/%h want 1/ff", bus.INSTR_VALID, bus.INSTR_ADDR); end
      n_checks++;
      if (bus.INSTR_DATA !== (8'hFF ^ 8'hA5)) begin n_fail++; $display("FAIL wrap_ff_data got %h want %h", bus.INSTR_DATA, 8'hFF ^ 8'hA5); end
      @(negedge CLK);
`ifdef ROM_PREFETCH_WRAP_EN
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'h00) begin n_fail++; $display("FAIL wrap_00 got %b/%h want 1/00", bus.INSTR_VALID, bus.INSTR_ADDR); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'h01) begin n_fail++; $display("FAIL wrap_01 got %b/%h want 1/01", bus.INSTR_VALID, bus.INSTR_ADDR); end
`else
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d] got %b want 0", i, bus.INSTR_VALID); end
         n_checks++;
         if (bus.ROM_ADDR !== 8'h00) begin n_fail++; $display("FAIL halt_pc[%0d] got %h want 00", i, bus.ROM_ADDR); end
         @(negedge CLK);
      end
      bus.JUMP_EN   = 1'b1;
      bus.JUMP_ADDR = 8'h10;
      @(negedge CLK);
      bus.JUMP_EN = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'h10) begin n_fail++; $display("FAIL halt_restart got %b/%h want 1/10", bus.INSTR_VALID, bus.INSTR_ADDR); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'h11) begin n_fail++; $display("FAIL halt_restart_next got %b/%h want 1/11", bus.INSTR_VALID, bus.INSTR_ADDR); end
`endif
   endtask

   task automatic test_async_reset();
      apply_reset();
      bus.INSTR_READY = 1'b1;
      repeat (6) @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got %b want 1", bus.INSTR_VALID); end
      #2;
      RESETn = 1'b0;
      #1;
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b want 0", bus.INSTR_VALID); end
      n_checks++;
      if (bus.ROM_ADDR !== 8'h00) begin n_fail++; $display("FAIL ar_rom_addr got %h want 00", bus.ROM_ADDR); end
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h00 || bus.INSTR_DATA !== 8'h00) begin n_fail++; $display("FAIL ar_head got %h/%h want 00/00", bus.INSTR_ADDR, bus.INSTR_DATA); end
      @(negedge CLK);
      RESETn = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL ar_edge1_valid got %b want 0", bus.INSTR_VALID); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_VALID !== 1'b1 || bus.INSTR_ADDR !== 8'h00 || bus.INSTR_DATA !== 8'hA5) begin n_fail++; $display("FAIL ar_edge2 got %b/%h/%h want 1/00/a5", bus.INSTR_VALID, bus.INSTR_ADDR, bus.INSTR_DATA); end
      @(negedge CLK);
      n_checks++;
      if (bus.INSTR_ADDR !== 8'h01 || bus.INSTR_DATA !== (8'h01 ^ 8'hA5)) begin n_fail++; $display("FAIL ar_next got %h/%h want 01/%h", bus.INSTR_ADDR, bus.INSTR_DATA, 8'h01 ^ 8'hA5); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
      RESETn          = 1'b0;
      bus.INSTR_READY = 1'b0;
      bus.JUMP_EN     = 1'b0;
      bus.JUMP_ADDR   = 8'h00;

      test_reset();
      test_stream();
      test_backpressure();
      test_jump_flush();
      test_jump_pop();
      test_wrap();
      test_async_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
